// File: rtl/carfield_apb_wdt.sv
// carfield_apb_wdt: APB system watchdog, prescaler -> down-counter -> RUN/WARN/BITE FSM.
// Define CARFIELD_WDT_DBG_FREEZE_EN to freeze prescaler and COUNT while dbg_halted_i is high.
module carfield_apb_wdt #(
   parameter int unsigned CntWidth   = 32,
   parameter int unsigned PrescWidth = 16,
   parameter logic [31:0] KickKey    = 32'h5A5A_A5A5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] paddr_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   input  logic [3:0]  pstrb_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   input  logic        dbg_halted_i,
   output logic        wdt_warn_irq_o,
   output logic        wdt_bite_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WARN = 2'd2;
   localparam logic [1:0] ST_BITE = 2'd3;

   localparam logic [11:0] OFF_CTRL    = 12'h000;
   localparam logic [11:0] OFF_PRESC   = 12'h004;
   localparam logic [11:0] OFF_TIMEOUT = 12'h008;
   localparam logic [11:0] OFF_WARN    = 12'h00C;
   localparam logic [11:0] OFF_KICK    = 12'h010;
   localparam logic [11:0] OFF_COUNT   = 12'h014;
   localparam logic [11:0] OFF_STATUS  = 12'h018;

   logic                  ctrl_en;
   logic                  ctrl_irq_en;
   logic                  ctrl_lock;
   logic [PrescWidth-1:0] presc;
   logic [PrescWidth-1:0] presc_cnt;
   logic [CntWidth-1:0]   timeout;
   logic [CntWidth-1:0]   warn;
   logic [CntWidth-1:0]   count;
   logic [1:0]            state;
   logic                  warn_pend;

   logic                  access;
   logic [11:0]           offset;
   logic                  hit_ctrl, hit_presc, hit_timeout, hit_warn;
   logic                  hit_kick, hit_count, hit_status;
   logic                  mapped, cfg_hit, running;
   logic                  err;
   logic                  wr_ok;
   logic [31:0]           rdata;
   logic                  en_rise, en_fall, kick, w1c;
   logic                  freeze, tick, tick_eff, enter_warn;
   logic [CntWidth-1:0]   count_dec;

`ifdef CARFIELD_WDT_DBG_FREEZE_EN
   logic unused;
   assign freeze = dbg_halted_i;
   assign unused = ^paddr_i[31:12];
`else
   logic unused;
   assign freeze = 1'b0;
   assign unused = ^{paddr_i[31:12], dbg_halted_i};
`endif

   assign access = psel_i & penable_i;
   assign offset = paddr_i[11:0];

   // Full 12-bit compares also reject misaligned offsets.
   assign hit_ctrl    = (offset == OFF_CTRL);
   assign hit_presc   = (offset == OFF_PRESC);
   assign hit_timeout = (offset == OFF_TIMEOUT);
   assign hit_warn    = (offset == OFF_WARN);
   assign hit_kick    = (offset == OFF_KICK);
   assign hit_count   = (offset == OFF_COUNT);
   assign hit_status  = (offset == OFF_STATUS);
   assign mapped  = hit_ctrl | hit_presc | hit_timeout | hit_warn | hit_kick | hit_count | hit_status;
   assign cfg_hit = hit_ctrl | hit_presc | hit_timeout | hit_warn;
   assign running = (state == ST_RUN) || (state == ST_WARN);

   always_comb begin
      err = 1'b0;
      if (!mapped) begin
         err = 1'b1;
      end else if (pwrite_i) begin
         if (pstrb_i != 4'hF) begin
            err = 1'b1;
         end else if (cfg_hit && ctrl_lock) begin
            err = 1'b1;
         end else if (hit_kick && ((pwdata_i != KickKey) || !running)) begin
            err = 1'b1;
         end
      end
   end

   assign wr_ok     = access & pwrite_i & ~err;
   assign pready_o  = 1'b1;
   assign pslverr_o = access & err;

   always_comb begin
      rdata = '0;
      if (hit_ctrl) begin
         rdata[0]  = ctrl_en;
         rdata[1]  = ctrl_irq_en;
         rdata[31] = ctrl_lock;
      end else if (hit_presc) begin
         rdata[PrescWidth-1:0] = presc;
      end else if (hit_timeout) begin
         rdata[CntWidth-1:0] = timeout;
      end else if (hit_warn) begin
         rdata[CntWidth-1:0] = warn;
      end else if (hit_count) begin
         rdata[CntWidth-1:0] = count;
      end else if (hit_status) begin
         rdata[3:0] = {state, (state == ST_BITE), warn_pend};
      end
   end

   assign prdata_o = access ? rdata : 32'h0;

   assign en_rise = wr_ok & hit_ctrl & pwdata_i[0] & ~ctrl_en & (state == ST_IDLE);
   assign en_fall = wr_ok & hit_ctrl & ~pwdata_i[0] & ctrl_en;
   assign kick    = wr_ok & hit_kick;
   assign w1c     = wr_ok & hit_status & pwdata_i[0];

   // >= keeps a shrunk PRESC from forcing a full wrap of the prescaler.
   assign tick      = running & ~freeze & (presc_cnt >= presc);
   assign tick_eff  = tick & ~en_fall & ~kick;
   assign count_dec = (count == '0) ? '0 : count - CntWidth'(1);
   assign enter_warn = tick_eff && (state == ST_RUN) && (count_dec != '0)
                       && (count_dec <= warn) && (warn != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         ctrl_lock   <= 1'b0;
         presc       <= '0;
         timeout     <= '0;
         warn        <= '0;
      end else if (wr_ok) begin
         if (hit_ctrl) begin
            ctrl_en     <= pwdata_i[0];
            ctrl_irq_en <= pwdata_i[1];
            ctrl_lock   <= ctrl_lock | pwdata_i[31];
         end
         if (hit_presc)   presc   <= pwdata_i[PrescWidth-1:0];
         if (hit_timeout) timeout <= pwdata_i[CntWidth-1:0];
         if (hit_warn)    warn    <= pwdata_i[CntWidth-1:0];
      end
   end

   // Priority in RUN/WARN: EN-clear, then KICK, then tick.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         count     <= '0;
         presc_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en_rise) begin
                  count     <= timeout;
                  presc_cnt <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN, ST_WARN: begin
               if (en_fall) begin
                  state <= ST_IDLE;
               end else if (kick) begin
                  count     <= timeout;
                  presc_cnt <= '0;
                  state     <= ST_RUN;
               end else if (!freeze) begin
                  if (tick) begin
                     presc_cnt <= '0;
                     count     <= count_dec;
                     if (count_dec == '0) begin
                        state <= ST_BITE;
                     end else if (enter_warn) begin
                        state <= ST_WARN;
                     end
                  end else begin
                     presc_cnt <= presc_cnt + PrescWidth'(1);
                  end
               end
            end
            default: state <= ST_BITE;
         endcase
      end
   end

   // A WARN entry in the same cycle as a W1C keeps the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         warn_pend <= 1'b0;
      end else if (enter_warn) begin
         warn_pend <= 1'b1;
      end else if (w1c) begin
         warn_pend <= 1'b0;
      end
   end

   assign wdt_warn_irq_o = warn_pend & ctrl_irq_en;
   assign wdt_bite_o     = (state == ST_BITE);

endmodule

// File: tb/tb_carfield_apb_wdt.sv
// Directed bench for carfield_apb_wdt: expectations queued at drive time, popped at observation.
module tb_carfield_apb_wdt;

   localparam logic [31:0] KEY     = 32'h5A5A_A5A5;
   localparam logic [31:0] BAD_KEY = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        dbg = 1'b0;
   logic        warn_irq;
   logic        bite;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   carfield_apb_wdt dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .paddr_i        (paddr),
      .psel_i         (psel),
      .penable_i      (penable),
      .pwrite_i       (pwrite),
      .pwdata_i       (pwdata),
      .pstrb_i        (pstrb),
      .prdata_o       (prdata),
      .pready_o       (pready),
      .pslverr_o      (pslverr),
      .dbg_halted_i   (dbg),
      .wdt_warn_irq_o (warn_irq),
      .wdt_bite_o     (bite)
   );

   task automatic push(input string t, input logic [31:0] e);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty observed=%h required=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_tests++;
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called #1 after an edge; the access phase closes at the second following edge.
   task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk);
      #1 penable = 1'b1;
      #1;
      rd = prdata;
      er = pslverr;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
   endtask

   task automatic wr(input string t, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic exp_err);
      logic [31:0] r;
      logic        e;
      push(t, {31'b0, exp_err});
      apb(1'b1, a, d, s, r, e);
      pop_check({31'b0, e});
   endtask

   task automatic rd(input string t, input logic [31:0] a, input logic [31:0] exp_v);
      logic [31:0] r;
      logic        e;
      push(t, exp_v);
      apb(1'b0, a, 32'h0, 4'h0, r, e);
      pop_check(r);
   endtask

   task automatic rd_err(input string t, input logic [31:0] a);
      logic [31:0] r;
      logic        e;
      push(t, 32'h1);
      apb(1'b0, a, 32'h0, 4'h0, r, e);
      pop_check({31'b0, e});
   endtask

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp_v);
      push(t, exp_v);
      pop_check(obs);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_async_bite", {31'b0, bite}, 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout observed=hang required=finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int          first_irq;
      int          first_bite;
      logic        bite_seen;
      logic [31:0] r;
      logic        e;

      // Reset state
      cyc(3);
      chk("rst_pready", {31'b0, pready}, 32'h1);
      chk("rst_bite", {31'b0, bite}, 32'h0);
      chk("rst_irq", {31'b0, warn_irq}, 32'h0);
      rst = 1'b0;
      cyc(1);
      for (int i = 0; i < 7; i++) begin
         rd($sformatf("rst_rd_%02h", i * 4), 32'(i * 4), 32'h0);
      end
      wr("kick_in_idle", 32'h10, KEY, 4'hF, 1'b1);

      // Warn then bite timing
      wr("cfg_presc", 32'h04, 32'd3, 4'hF, 1'b0);
      wr("cfg_timeout", 32'h08, 32'd10, 4'hF, 1'b0);
      wr("cfg_warn", 32'h0C, 32'd4, 4'hF, 1'b0);
      rd("rb_presc", 32'h04, 32'd3);
      rd("rb_timeout", 32'h08, 32'd10);
      rd("rb_warn", 32'h0C, 32'd4);
      wr("cfg_ctrl", 32'h00, 32'h3, 4'hF, 1'b0);
      first_irq = -1;
      first_bite = -1;
      for (int k = 1; k <= 60; k++) begin
         cyc(1);
         if (warn_irq && first_irq < 0) first_irq = k;
         if (bite && first_bite < 0) first_bite = k;
      end
      chk("warn_irq_rise_cycle", 32'(first_irq), 32'd24);
      chk("bite_rise_cycle", 32'(first_bite), 32'd40);
      cyc(20);
      chk("bite_sticky", {31'b0, bite}, 32'h1);
      rd("status_bite", 32'h18, 32'hF);
      rd("count_bite", 32'h14, 32'h0);
      wr("kick_in_bite", 32'h10, KEY, 4'hF, 1'b1);
      wr("warn_wr_in_bite", 32'h0C, 32'd7, 4'hF, 1'b0);
      rd("warn_rb_in_bite", 32'h0C, 32'd7);
      wr("status_w1c", 32'h18, 32'h1, 4'hF, 1'b0);
      rd("status_after_w1c", 32'h18, 32'hE);
      chk("irq_after_w1c", {31'b0, warn_irq}, 32'h0);
      do_reset();
      chk("bite_after_reset", {31'b0, bite}, 32'h0);

      // Periodic kicks keep it alive
      wr("cfg_presc2", 32'h04, 32'd3, 4'hF, 1'b0);
      wr("cfg_timeout2", 32'h08, 32'd10, 4'hF, 1'b0);
      wr("cfg_warn2", 32'h0C, 32'd4, 4'hF, 1'b0);
      wr("cfg_ctrl2", 32'h00, 32'h3, 4'hF, 1'b0);
      bite_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < 26; c++) begin
            cyc(1);
            if (bite) bite_seen = 1'b1;
         end
         rd($sformatf("count_before_kick_%0d", i), 32'h14, 32'd4);
         wr($sformatf("kick_ok_%0d", i), 32'h10, KEY, 4'hF, 1'b0);
      end
      chk("kick_no_bite", {31'b0, bite_seen}, 32'h0);
      wr("kick_bad_key", 32'h10, BAD_KEY, 4'hF, 1'b1);
      rd("count_after_bad_kick", 32'h14, 32'd10);
      wr("partial_strobe", 32'h08, 32'd5, 4'h3, 1'b1);
      rd_err("misaligned_rd", 32'h02);
      rd_err("unmapped_rd", 32'h1C);
      rd("timeout_unchanged", 32'h08, 32'd10);

      // KICK landing on the tick that would take COUNT 1 -> 0
      wr("kick_sync", 32'h10, KEY, 4'hF, 1'b0);
      cyc(36);
      rd("count_is_one", 32'h14, 32'd1);
      wr("kick_on_tick", 32'h10, KEY, 4'hF, 1'b0);
      rd("count_reloaded", 32'h14, 32'd10);
      rd("status_run_after_kick", 32'h18, 32'h5);
      chk("no_bite_after_kick", {31'b0, bite}, 32'h0);

      // Lock
      wr("lock_set", 32'h00, 32'h8000_0001, 4'hF, 1'b0);
      rd("lock_rb", 32'h00, 32'h8000_0001);
      wr("locked_timeout_wr", 32'h08, 32'd5, 4'hF, 1'b1);
      rd("locked_timeout_rb", 32'h08, 32'd10);
      wr("locked_ctrl_wr", 32'h00, 32'h0, 4'hF, 1'b1);
      rd("locked_ctrl_rb", 32'h00, 32'h8000_0001);
      apb(1'b0, 32'h18, 32'h0, 4'h0, r, e);
      chk("locked_state_run", r & 32'hC, 32'h4);
      do_reset();
      rd("lock_cleared_by_reset", 32'h00, 32'h0);

      // Debug halt
      wr("dbg_presc", 32'h04, 32'd9, 4'hF, 1'b0);
      wr("dbg_timeout", 32'h08, 32'd50, 4'hF, 1'b0);
      wr("dbg_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
      dbg = 1'b1;
      cyc(100);
      dbg = 1'b0;
`ifdef CARFIELD_WDT_DBG_FREEZE_EN
      rd("dbg_count", 32'h14, 32'd50);
`else
      rd("dbg_count", 32'h14, 32'd40);
`endif
      chk("dbg_no_bite", {31'b0, bite}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
